gameover_ctrl: RTL and testbench

Round-end sequencer for the two-player game. Watches both players' collision flags and decides the winner, with a short settle window so near-simultaneous crashes are scored as a draw. It then freezes gameplay, drives the game-over overlay's `winner_latched` and enable inputs, and waits for a fresh start-button press before issuing a one-cycle restart. It sits between the game logic / collision detectors and the game-over overlay renderer in the 1024x768 draw chain.

---
 rtl/gameover_ctrl.sv | 165 ++++++++++++++++
 tb/tb_gameover_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/gameover_ctrl.sv
// gameover_ctrl: round-end sequencer for the two-player game.
//   Watches both collision flags and opens a short settle window so that
//   near-simultaneous crashes score as a draw. It then freezes gameplay and
//   shows the overlay. After a minimum hold it waits for a fresh start-button
//   press and issues a one-cycle restart.
// Ports:
//   clk, rst          : pixel clock and synchronous active-high reset
//   frame_tick        : one-cycle pulse per frame
//   p1_hit, p2_hit    : collision flags, level or pulse
//   start_btn         : synchronised, debounced start button (level)
//   winner_latched    : 00 none, 01 P1 wins, 10 P2 wins, 11 draw
//   overlay_en        : overlay visible
//   freeze            : hold game positions
//   restart           : one-cycle reinitialise pulse
// Optional feature: define GAMEOVER_BLINK_EN to blink the overlay in WAIT_BTN.
// All outputs are registered. Outputs already reflect a state on the edge
// that enters it.
module gameover_ctrl #(
  parameter int SETTLE_FRAMES = 2,
  parameter int HOLD_FRAMES   = 120,
  parameter int BLINK_FRAMES  = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       p1_hit,
  input  logic       p2_hit,
  input  logic       start_btn,
  output logic [1:0] winner_latched,
  output logic       overlay_en,
  output logic       freeze,
  output logic       restart
);

  localparam int MAX_SH = (SETTLE_FRAMES > HOLD_FRAMES) ? SETTLE_FRAMES : HOLD_FRAMES;
  localparam int MAXF   = (MAX_SH > BLINK_FRAMES) ? MAX_SH : BLINK_FRAMES;
  localparam int CW     = $clog2(MAXF + 1);

  typedef enum logic [2:0] {
    PLAY,
    SETTLE,
    SHOW,
    WAIT_BTN,
    RESTART
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          h1;
  logic          h2;
  logic          btn_prev;

  logic [CW-1:0] cnt_inc;
  logic          n1;
  logic          n2;
  logic          btn_edge;

  assign cnt_inc  = cnt + CW'(1);
  // A hit in the cycle that closes the settle window still counts.
  assign n1       = h1 | p1_hit;
  assign n2       = h2 | p2_hit;
  assign btn_edge = start_btn & ~btn_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= PLAY;
      cnt            <= '0;
      h1             <= 1'b0;
      h2             <= 1'b0;
      btn_prev       <= 1'b0;
      winner_latched <= 2'b00;
      overlay_en     <= 1'b0;
      freeze         <= 1'b0;
      restart        <= 1'b0;
    end else begin
      // History updates in every state so the edge detector is valid on entry.
      btn_prev <= start_btn;
      case (state)
        PLAY: begin
          winner_latched <= 2'b00;
          overlay_en     <= 1'b0;
          freeze         <= 1'b0;
          restart        <= 1'b0;
          // A tick coincident with the first hit is not counted.
          if (p1_hit || p2_hit) begin
            state <= SETTLE;
            h1    <= p1_hit;
            h2    <= p2_hit;
            cnt   <= '0;
          end
        end

        SETTLE: begin
          // Gameplay keeps running, so the other bird can still crash.
          h1 <= n1;
          h2 <= n2;
          if (frame_tick) begin
            if (cnt_inc == CW'(SETTLE_FRAMES)) begin
              state          <= SHOW;
              cnt            <= '0;
              // A P1 crash means P2 wins: bit 1 is P2, bit 0 is P1.
              winner_latched <= {n1, n2};
              overlay_en     <= 1'b1;
              freeze         <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end

        SHOW: begin
          if (frame_tick) begin
            if (cnt_inc == CW'(HOLD_FRAMES)) begin
              state      <= WAIT_BTN;
              cnt        <= '0;
              overlay_en <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end

        WAIT_BTN: begin
          if (btn_edge) begin
            state          <= RESTART;
            cnt            <= '0;
            restart        <= 1'b1;
            overlay_en     <= 1'b0;
            winner_latched <= 2'b00;
          end else if (frame_tick) begin
`ifdef GAMEOVER_BLINK_EN
            if (cnt_inc == CW'(BLINK_FRAMES)) begin
              cnt        <= '0;
              overlay_en <= ~overlay_en;
            end else begin
              cnt <= cnt_inc;
            end
`else
            overlay_en <= 1'b1;
`endif
          end
        end

        RESTART: begin
          state   <= PLAY;
          cnt     <= '0;
          h1      <= 1'b0;
          h2      <= 1'b0;
          restart <= 1'b0;
          freeze  <= 1'b0;
        end

        default: begin
          state          <= PLAY;
          cnt            <= '0;
          winner_latched <= 2'b00;
          overlay_en     <= 1'b0;
          freeze         <= 1'b0;
          restart        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gameover_ctrl.sv
// tb_gameover_ctrl: directed bench for gameover_ctrl.
//   Uses SETTLE_FRAMES=2, HOLD_FRAMES=4, BLINK_FRAMES=2. Inputs change and
//   outputs are checked 1 time unit after each rising edge.
module tb_gameover_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       p1_hit;
  logic       p2_hit;
  logic       start_btn;
  logic [1:0] winner_latched;
  logic       overlay_en;
  logic       freeze;
  logic       restart;

  int errors = 0;
  int checks = 0;

  gameover_ctrl #(
    .SETTLE_FRAMES(2),
    .HOLD_FRAMES  (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .p1_hit        (p1_hit),
    .p2_hit        (p2_hit),
    .start_btn     (start_btn),
    .winner_latched(winner_latched),
    .overlay_en    (overlay_en),
    .freeze        (freeze),
    .restart       (restart)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // Pack {winner_latched, overlay_en, freeze}; restart checked separately.
  function automatic logic [3:0] outs();
    return {winner_latched, overlay_en, freeze};
  endfunction

  // From entry into SHOW: finish hold, press, check restart, release.
  task automatic finish_round(input string tag);
    repeat (4) tick();
    start_btn = 1'b1;
    step();
    chk({tag, "_restart"}, {3'b0, restart}, 4'b0001);
    start_btn = 1'b0;
    step();
    chk({tag, "_play"}, {outs()}, 4'b0000);
  endtask

  initial begin
    logic [5:0] blink_exp;
    rst = 1'b1; frame_tick = 1'b0; p1_hit = 1'b0; p2_hit = 1'b0; start_btn = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("reset_outs", outs(), 4'b0000);
    chk("reset_restart", {3'b0, restart}, 4'b0000);

    // 1: P1 crash only -> P2 wins.
    p1_hit = 1'b1; step(); p1_hit = 1'b0;
    chk("t1_settle", outs(), 4'b0000);
    tick();
    chk("t1_tick1", outs(), 4'b0000);
    tick();
    chk("t1_show", outs(), 4'b1011);
    repeat (3) tick();
    chk("t1_hold", outs(), 4'b1011);
    tick();
    chk("t1_wait", outs(), 4'b1011);
    start_btn = 1'b1; step();
    chk("t1_restart", {restart, winner_latched, overlay_en}, 4'b1000);
    chk("t1_restart_frz", {3'b0, freeze}, 4'b0001);
    start_btn = 1'b0; step();
    chk("t1_play", {restart, outs()[2:0]}, 4'b0000);
    chk("t1_play_win", {2'b0, winner_latched}, 4'b0000);

    // P2 crash only -> P1 wins.
    p2_hit = 1'b1; step(); p2_hit = 1'b0;
    tick(); tick();
    chk("p2only_show", outs(), 4'b0111);
    finish_round("p2only");

    // 2a: P2, then P1 after one tick -> draw.
    p2_hit = 1'b1; step(); p2_hit = 1'b0;
    tick();
    p1_hit = 1'b1; step(); p1_hit = 1'b0;
    tick();
    chk("t2a_draw", outs(), 4'b1111);
    finish_round("t2a");

    // 2b: P2 hit coincident with the closing tick -> draw.
    p1_hit = 1'b1; step(); p1_hit = 1'b0;
    tick();
    p2_hit = 1'b1; tick(); p2_hit = 1'b0;
    chk("t2b_draw", outs(), 4'b1111);
    finish_round("t2b");

    // 3: button held from SETTLE into WAIT_BTN gives no edge.
    p1_hit = 1'b1; step(); p1_hit = 1'b0;
    start_btn = 1'b1;
    tick(); tick();
    repeat (4) tick();
    step(); step();
    chk("t3_held", {restart, outs()[2:0]}, 4'b0011);
    start_btn = 1'b0; step();
    chk("t3_release", {3'b0, restart}, 4'b0000);
    start_btn = 1'b1; step();
    chk("t3_press", {3'b0, restart}, 4'b0001);
    step();
    chk("t3_one_cycle", {restart, outs()[2:0]}, 4'b0000);
    chk("t3_win_clear", {2'b0, winner_latched}, 4'b0000);
    start_btn = 1'b0; step();

    // 4: button edge during SHOW is ignored.
    p2_hit = 1'b1; step(); p2_hit = 1'b0;
    tick(); tick();
    tick();
    start_btn = 1'b1; step();
    chk("t4_show_btn", {restart, outs()[2:0]}, 4'b0111);
    start_btn = 1'b0; step();
    repeat (3) tick();
    step();
    chk("t4_wait", {restart, outs()[2:0]}, 4'b0111);
    start_btn = 1'b1; step();
    chk("t4_press", {3'b0, restart}, 4'b0001);
    start_btn = 1'b0; step();

    // 5a: reset mid-SETTLE.
    p1_hit = 1'b1; step(); p1_hit = 1'b0;
    tick();
    rst = 1'b1; step(); rst = 1'b0;
    chk("t5a_outs", {restart, outs()[2:0]}, 4'b0000);
    chk("t5a_win", {2'b0, winner_latched}, 4'b0000);
    tick(); tick();
    chk("t5a_play", outs(), 4'b0000);

    // 5b: reset mid-WAIT_BTN.
    p1_hit = 1'b1; step(); p1_hit = 1'b0;
    tick(); tick();
    repeat (4) tick();
    step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("t5b_outs", {restart, outs()[2:0]}, 4'b0000);
    chk("t5b_win", {2'b0, winner_latched}, 4'b0000);
    repeat (3) tick();
    chk("t5b_play", outs(), 4'b0000);

    // 6: overlay pattern over ticks 1..6 in WAIT_BTN.
`ifdef GAMEOVER_BLINK_EN
    blink_exp = 6'b100110;
`else
    blink_exp = 6'b111111;
`endif
    p2_hit = 1'b1; step(); p2_hit = 1'b0;
    tick(); tick();
    repeat (4) tick();
    chk("t6_entry", {3'b0, overlay_en}, 4'b0001);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("t6_tick%0d", i + 1), {3'b0, overlay_en}, {3'b0, blink_exp[5 - i]});
    end
    chk("t6_frz", {freeze, restart, winner_latched}, 4'b1001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
